// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the stream header arbiter.
// Holds the FSM state encoding and the keep-vector checks.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PKT
  } state_t;

  localparam int MAX_KEEP_WD = 64;
  localparam int WDOG_CNT_WD = 16;

  function automatic int popcount(
    input logic [MAX_KEEP_WD-1:0] v
  );
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEEP_WD; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

  // Nonzero, packed from bit0, and never a full word.
  function automatic logic keep_legal(
    input logic [MAX_KEEP_WD-1:0] k,
    input int                     nbytes
  );
    logic contig;
    contig = ((k & (k + 64'd1)) == '0);
    return (k != '0) && contig &&
           (popcount(k) <= nbytes - 1);
  endfunction

endpackage

// File: rtl/axis_header_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant,
// searching upward from ptr with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_WD  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_WD-1:0]  ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_WD-1:0]  gnt_idx,
  output logic               any
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_WD'(j);
      end
    end
  end

endmodule

// File: rtl/axis_header_arbiter.sv
// Round-robin header-insert scheduler, grant held to last beat.
// Optional packet watchdog: define HDR_ARB_WATCHDOG_EN.
module axis_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int IDX_WD       = $clog2(NUM_REQ),
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            valid_in,
  input  logic                            ready_in,
  input  logic                            last_in,
  output logic [IDX_WD-1:0]               grant_idx,
  output logic                            busy,
  output logic                            keep_err,
  output logic                            wdog_err
);

  import axis_hdr_pkg::*;

  if (NUM_REQ < 2 || WDOG_CYCLES < 2) begin : g_cfg_check
    $error("axis_header_arbiter: bad parameters");
  end

  state_t state_q, state_d;

  logic [IDX_WD-1:0]       rr_ptr_q;
  logic [IDX_WD-1:0]       grant_idx_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic [BYTE_CNT_WD-1:0]  cnt_q;
  logic                    keep_err_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_WD-1:0]       arb_idx;
  logic                    arb_any;
  logic [DATA_WD-1:0]      sel_data;
  logic [DATA_BYTE_WD-1:0] sel_keep;
  logic                    sel_legal;
  logic                    accept;
  logic                    last_hs;
  logic                    pkt_done;
  logic                    wdog_fire;

  function automatic logic [IDX_WD-1:0] nxt_idx(
    input logic [IDX_WD-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_WD  (IDX_WD)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    sel_data = req_data[int'(arb_idx)*DATA_WD +: DATA_WD];
    sel_keep =
      req_keep[int'(arb_idx)*DATA_BYTE_WD +: DATA_BYTE_WD];
    sel_legal =
      keep_legal(MAX_KEEP_WD'(sel_keep), DATA_BYTE_WD);
  end

  assign accept   = (state_q == IDLE) && arb_any;
  assign last_hs  = valid_in && ready_in && last_in;
  assign pkt_done = (state_q == PKT) && last_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (arb_any && sel_legal) state_d = HDR;
      HDR:  if (ready_insert) state_d = PKT;
      PKT:  if (last_hs || wdog_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      cnt_q       <= '0;
      keep_err_q  <= 1'b0;
    end else begin
      keep_err_q <= 1'b0;
      if (accept) begin
        grant_idx_q <= arb_idx;
        data_q      <= sel_data;
        keep_q      <= sel_keep;
        cnt_q       <=
          BYTE_CNT_WD'(popcount(MAX_KEEP_WD'(sel_keep)));
        // A malformed header is swallowed; its owner loses its turn.
        if (!sel_legal) begin
          keep_err_q <= 1'b1;
          rr_ptr_q   <= nxt_idx(arb_idx);
        end
      end
      if (pkt_done || wdog_fire) begin
        rr_ptr_q <= nxt_idx(grant_idx_q);
      end
    end
  end

`ifdef HDR_ARB_WATCHDOG_EN
  logic [WDOG_CNT_WD-1:0] wdog_cnt_q;
  logic                   wdog_err_q;

  assign wdog_fire = (state_q == PKT) && !last_hs &&
    (wdog_cnt_q == WDOG_CNT_WD'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_fire;
      if (state_q == PKT) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end else begin
        wdog_cnt_q <= '0;
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Gate on rst_n so no header is taken while reset is held.
  assign req_ready =
    (rst_n && state_q == IDLE) ? arb_gnt : '0;

  assign valid_insert    = (state_q == HDR);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign grant_idx       = grant_idx_q;
  assign busy            = (state_q != IDLE);
  assign keep_err        = keep_err_q;

endmodule

// File: tb/tb_axis_header_arbiter.sv
// Directed self-checking bench for axis_header_arbiter.
// Watchdog path is exercised when HDR_ARB_WATCHDOG_EN is defined.
module tb_axis_header_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [15:0]  req_keep;
  logic [3:0]   req_ready;
  logic         valid_insert;
  logic [31:0]  data_insert;
  logic [3:0]   keep_insert;
  logic [1:0]   byte_insert_cnt;
  logic         ready_insert;
  logic         valid_in;
  logic         ready_in;
  logic         last_in;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         keep_err;
  logic         wdog_err;

  int checks;
  int failures;

  axis_header_arbiter #(
    .DATA_WD     (32),
    .NUM_REQ     (4),
    .WDOG_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .last_in         (last_in),
    .grant_idx       (grant_idx),
    .busy            (busy),
    .keep_err        (keep_err),
    .wdog_err        (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i,
                         input logic [31:0] d,
                         input logic [3:0] k);
    req_data[i*32 +: 32] = d;
    req_keep[i*4 +: 4]   = k;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      ready_in = 1'b1;
      last_in  = (i == n - 1);
      #1;
      chk("pkt_busy", busy, 1);
      chk("pkt_no_ready", req_ready, 0);
      tick();
    end
    valid_in = 1'b0;
    ready_in = 1'b0;
    last_in  = 1'b0;
    chk("pkt_end_idle", busy, 0);
  endtask

  task automatic hdr_accept();
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    chk("hdr_done_valid", valid_insert, 0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_keep     = '0;
    ready_insert = 1'b0;
    valid_in     = 1'b0;
    ready_in     = 1'b0;
    last_in      = 1'b0;

    // Reset state
    repeat (3) tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valid", valid_insert, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_data", data_insert, 0);
    chk("rst_keep", keep_insert, 0);
    chk("rst_cnt", byte_insert_cnt, 0);
    chk("rst_keep_err", keep_err, 0);
    chk("rst_wdog_err", wdog_err, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // 1: single source, 8-beat packet
    set_src(0, 32'hA0A0_0001, 4'b0011);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_idle", busy, 0);
    tick();
    req_valid = '0;
    chk("t1_valid", valid_insert, 1);
    chk("t1_data", data_insert, 32'hA0A0_0001);
    chk("t1_keep", keep_insert, 4'b0011);
    chk("t1_cnt", byte_insert_cnt, 2);
    chk("t1_grant", grant_idx, 0);
    chk("t1_hdr_ready", req_ready, 0);
    hdr_accept();
    valid_in = 1'b1;
    ready_in = 1'b0;
    last_in  = 1'b1;
    tick();
    chk("t1_stall_busy", busy, 1);
    send_pkt(8);

    // 2: all four request, round-robin order
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_src(k, 32'hB000_0000 + k, 4'b0001);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_ready", req_ready, 64'd1 << (k % 4));
      tick();
      chk("t2_grant", grant_idx, k % 4);
      chk("t2_data", data_insert, 32'hB000_0000 + (k % 4));
      chk("t2_hdr_ready", req_ready, 0);
      hdr_accept();
      send_pkt(2);
    end

    // 3: header held while ready_insert is low
    req_valid = 4'b0010;
    set_src(1, 32'h1111_2222, 4'b0111);
    #1;
    chk("t3_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", valid_insert, 1);
      chk("t3_data", data_insert, 32'h1111_2222);
      chk("t3_keep", keep_insert, 4'b0111);
      chk("t3_cnt", byte_insert_cnt, 3);
      tick();
    end
    chk("t3_valid_end", valid_insert, 1);
    hdr_accept();
    send_pkt(1);

    // 4: malformed keeps from source 2
    set_src(2, 32'hC2C2_C2C2, 4'b1111);
    req_valid = 4'b0100;
    #1;
    chk("t4a_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("t4a_keep_err", keep_err, 1);
    chk("t4a_valid", valid_insert, 0);
    chk("t4a_busy", busy, 0);
    tick();
    chk("t4a_keep_err_off", keep_err, 0);
    chk("t4a_valid2", valid_insert, 0);
    set_src(2, 32'hC2C2_C2C2, 4'b0101);
    req_valid = 4'b0100;
    #1;
    chk("t4b_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("t4b_keep_err", keep_err, 1);
    chk("t4b_valid", valid_insert, 0);
    set_src(0, 32'hD0D0_0000, 4'b0001);
    set_src(3, 32'hD3D3_0000, 4'b0001);
    req_valid = 4'b1101;
    #1;
    chk("t4_ptr3_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("t4_grant3", grant_idx, 3);
    chk("t4_valid3", valid_insert, 1);
    hdr_accept();
    send_pkt(1);

    // 5: reset in the middle of a packet
    set_src(2, 32'hE2E2_0000, 4'b0001);
    req_valid = 4'b0100;
    #1;
    chk("t5_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    hdr_accept();
    valid_in = 1'b1;
    ready_in = 1'b1;
    tick();
    req_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", valid_insert, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant_idx, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_data", data_insert, 0);
    chk("t5_rst_cnt", byte_insert_cnt, 0);
    valid_in = 1'b0;
    ready_in = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_first_src0", req_ready, 4'b0001);
    tick();
    chk("t5_grant0", grant_idx, 0);
    hdr_accept();
    chk("t5_pkt_busy", busy, 1);

`ifdef HDR_ARB_WATCHDOG_EN
    // 6: last never arrives, watchdog recovers
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t6_wait_busy", busy, 1);
      chk("t6_wait_wdog", wdog_err, 0);
    end
    tick();
    chk("t6_wdog_err", wdog_err, 1);
    chk("t6_idle", busy, 0);
    chk("t6_next_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("t6_wdog_off", wdog_err, 0);
    chk("t6_grant1", grant_idx, 1);
    chk("t6_valid", valid_insert, 1);
    hdr_accept();
    send_pkt(1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_hold_busy", busy, 1);
      chk("t6_no_wdog", wdog_err, 0);
    end
    send_pkt(1);
    #1;
    chk("t6_next_ready", req_ready, 4'b0010);
    req_valid = '0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
